// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// scan state codes and the active-high {g,f,e,d,c,b,a} hex glyph table.
package seven_seg_scanner_pkg;

   localparam int SEG_W = 7;

   localparam logic [0:0] ST_GUARD = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   // Entry i is the glyph for nibble value i (index 15 is leftmost).
   localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg7.sv
// Combinational nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
// Polarity for the board is applied by the caller.
module hex_to_seg7
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0]       nibble_i,
   output logic [SEG_W-1:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes N hex digits onto one segment bus with an all-off guard between digits;
// the displayed value is latched once per frame so a digit never shows a torn update.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int GUARD_CLKS  = 8,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit AN_ACT_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  scan_tick,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  lz_blank,
   output logic [SEG_W-1:0]      seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_start
);

   localparam int IDX_W = $clog2(N_DIGITS);
   localparam int CNT_W = $clog2(GUARD_CLKS) + 1;

   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(GUARD_CLKS - 1);
   localparam logic [SEG_W-1:0]    SEG_OFF    = {SEG_W{SEG_ACT_LOW}};
   localparam logic                DP_OFF     = SEG_ACT_LOW;
   localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{AN_ACT_LOW}};

   logic [0:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0] val_q, val_d;
   logic [N_DIGITS-1:0]   dpm_q, dpm_d;
   logic [N_DIGITS-1:0]   en_q, en_d;
   logic                  lz_q, lz_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  fs_q, fs_d;

   logic [3:0]            cur_nib;
   logic [SEG_W-1:0]      glyph;
   logic [N_DIGITS-1:0]   upper_zero;
   logic                  zero_run;
   logic                  blank;
   logic [N_DIGITS-1:0]   an_sel;

   assign cur_nib = val_q[4*idx_q +: 4];

   hex_to_seg7 u_dec (
      .nibble_i (cur_nib),
      .seg_o    (glyph)
   );

   // upper_zero[i]: every shadow nibble from the MSD down to digit i is zero.
   always_comb begin
      zero_run   = 1'b1;
      upper_zero = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run & (val_q[4*i +: 4] == 4'd0);
         upper_zero[i] = zero_run;
      end
   end

   assign blank  = !en_q[idx_q] || (lz_q && upper_zero[idx_q] && (idx_q != '0));
   assign an_sel = N_DIGITS'(1) << idx_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      dpm_d   = dpm_q;
      en_d    = en_q;
      lz_d    = lz_q;
      seg_d   = SEG_OFF;
      dp_d    = DP_OFF;
      an_d    = AN_OFF;
      fs_d    = 1'b0;
      if (!enable) begin
         state_d = ST_GUARD;
         cnt_d   = CNT_RELOAD;
      end else if (state_q == ST_GUARD) begin
         if (cnt_q == '0) begin
            state_d = ST_SHOW;
            an_d    = an_sel ^ AN_OFF;
            seg_d   = (blank ? {SEG_W{1'b0}} : glyph) ^ SEG_OFF;
            dp_d    = (!blank && dpm_q[idx_q]) ^ DP_OFF;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end else if (scan_tick) begin
         state_d = ST_GUARD;
         cnt_d   = CNT_RELOAD;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            val_d = value;
            dpm_d = dp_in;
            en_d  = digit_en;
            lz_d  = lz_blank;
            fs_d  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         seg_d = seg_q;
         dp_d  = dp_q;
         an_d  = an_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_GUARD;
         idx_q   <= '0;
         cnt_q   <= CNT_RELOAD;
         val_q   <= '0;
         dpm_q   <= '0;
         en_q    <= '0;
         lz_q    <= 1'b0;
         seg_q   <= SEG_OFF;
         dp_q    <= DP_OFF;
         an_q    <= AN_OFF;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         dpm_q   <= dpm_d;
         en_q    <= en_d;
         lz_q    <= lz_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         fs_q    <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = fs_q;

endmodule
